// File: rtl/ccr_pkg.sv
// ---------------------------------------------------------------------------
// ccr_pkg
// Shared definitions for the condition-code register (CCR) controller and for
// the Execute/ALU decode that produces its inputs.
//   FW                 : flag width (Z, N, C)
//   FLAG_Z/FLAG_N/FLAG_C: bit positions of each flag inside the CCR
//   br_cond_e          : conditional-jump condition encodings
// ---------------------------------------------------------------------------
package ccr_pkg;

  localparam int FW = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    BR_JZ  = 2'b00,
    BR_JN  = 2'b01,
    BR_JC  = 2'b10,
    BR_JMP = 2'b11
  } br_cond_e;

endpackage : ccr_pkg

// File: rtl/ccr_controller_stack.sv
// ---------------------------------------------------------------------------
// flag_shadow_stack
// DEPTH x FW LIFO holding saved condition codes across nested interrupts.
// Push while full and pop while empty are ignored here; the caller decides
// what those events mean.
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   push_i     : write data_i on top
//   pop_i      : remove the top entry
//   data_i     : value to push
//   top_o      : current top entry (valid when !empty_o)
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
//   depth_o    : occupancy
// ---------------------------------------------------------------------------
module flag_shadow_stack #(
  parameter int DEPTH = 4,
  parameter int FW    = 3,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [FW-1:0] data_i,
  output logic [FW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] depth_o
);

  logic [FW-1:0] mem_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (depth_q == DW'(DEPTH));
  assign empty_o  = (depth_q == '0);
  assign depth_o  = depth_q;
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o & ~push_i;
  assign depth_m1 = depth_q - DW'(1);
  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];
  assign top_o    = mem_q[rd_idx];

  // NOTE: occupancy is the only thing reset has to clear; the storage array is
  // left unreset because an empty stack never exposes its stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + DW'(1);
    end else if (do_pop) begin
      depth_q <= depth_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule : flag_shadow_stack

// File: rtl/ccr_controller.sv
// ---------------------------------------------------------------------------
// ccr_controller
// Owns the condition-code register next to Execute: masked ALU flag writes,
// SETC/CLRC, conditional-jump resolution (a taken JZ/JN/JC clears the tested
// flag), and save/restore of the flags through a shadow stack on interrupt
// entry / RTI.
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall_i         : hold all state, suppress branch_taken_o
//   alu_flag_i      : ALU flags this cycle
//   flag_we_i       : per-bit write mask for alu_flag_i
//   setc_i, clrc_i  : set / clear C (set wins)
//   br_check_i      : jump in Execute
//   br_cond_i       : JZ / JN / JC / JMP
//   int_save_i      : interrupt entry, push merged flags
//   rti_restore_i   : RTI, pop flags
//   flags_o         : registered CCR
//   branch_taken_o  : combinational jump decision from registered flags
//   depth_o         : shadow-stack occupancy
//   ovf_err_o       : sticky, push while full
//   udf_err_o       : sticky, pop while empty
// ---------------------------------------------------------------------------
module ccr_controller #(
  parameter int DEPTH = 4,
  parameter int FW    = ccr_pkg::FW,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic [FW-1:0] alu_flag_i,
  input  logic [FW-1:0] flag_we_i,
  input  logic          setc_i,
  input  logic          clrc_i,
  input  logic          br_check_i,
  input  logic [1:0]    br_cond_i,
  input  logic          int_save_i,
  input  logic          rti_restore_i,
  output logic [FW-1:0] flags_o,
  output logic          branch_taken_o,
  output logic [DW-1:0] depth_o,
  output logic          ovf_err_o,
  output logic          udf_err_o
);

  import ccr_pkg::*;

  logic [FW-1:0] flags_q, flags_d;
  logic [FW-1:0] merged;
  logic [FW-1:0] clr_mask;
  logic [FW-1:0] stk_top;
  logic          stk_full, stk_empty;
  logic          tested;
  logic          taken;
  logic          save_ev, rti_ev;
  logic          ovf_q, udf_q;
  br_cond_e      cond;

  assign cond = br_cond_e'(br_cond_i);

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    tested   = 1'b1;
    clr_mask = '0;
    unique case (cond)
      BR_JZ: begin
        tested           = flags_q[FLAG_Z];
        clr_mask[FLAG_Z] = 1'b1;
      end
      BR_JN: begin
        tested           = flags_q[FLAG_N];
        clr_mask[FLAG_N] = 1'b1;
      end
      BR_JC: begin
        tested           = flags_q[FLAG_C];
        clr_mask[FLAG_C] = 1'b1;
      end
      BR_JMP: tested = 1'b1;
      default: tested = 1'b1;
    endcase
  end

  assign taken          = br_check_i & ~stall_i & tested;
  assign branch_taken_o = taken;

  // Merge order: masked ALU write, then SETC/CLRC, then taken-jump clear.
  always_comb begin
    merged = (alu_flag_i & flag_we_i) | (flags_q & ~flag_we_i);
    if (setc_i) begin
      merged[FLAG_C] = 1'b1;
    end else if (clrc_i) begin
      merged[FLAG_C] = 1'b0;
    end
    if (taken) begin
      merged = merged & ~clr_mask;
    end
  end

  // Interrupt entry outranks RTI; an RTI in the same cycle is dropped.
  assign save_ev = int_save_i & ~stall_i;
  assign rti_ev  = rti_restore_i & ~int_save_i & ~stall_i;

  always_comb begin
    flags_d = flags_q;
    if (save_ev) begin
      flags_d = merged;
    end else if (rti_ev && !stk_empty) begin
      flags_d = stk_top;
    end else if (!stall_i) begin
      flags_d = merged;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (save_ev && stk_full) ovf_q <= 1'b1;
      if (rti_ev && stk_empty) udf_q <= 1'b1;
    end
  end

  flag_shadow_stack #(
    .DEPTH (DEPTH),
    .FW    (FW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (save_ev),
    .pop_i   (rti_ev),
    .data_i  (merged),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .depth_o (depth_o)
  );

  assign flags_o   = flags_q;
  assign ovf_err_o = ovf_q;
  assign udf_err_o = udf_q;

endmodule : ccr_controller

// File: tb/tb_ccr_controller.sv
// ---------------------------------------------------------------------------
// tb_ccr_controller
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a behavioural model (flag value, queue-based
// stack, sticky error bits).
// ---------------------------------------------------------------------------
module tb_ccr_controller;

  localparam int DEPTH = 4;
  localparam int FW    = 3;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          stall_i;
  logic [FW-1:0] alu_flag_i;
  logic [FW-1:0] flag_we_i;
  logic          setc_i;
  logic          clrc_i;
  logic          br_check_i;
  logic [1:0]    br_cond_i;
  logic          int_save_i;
  logic          rti_restore_i;
  logic [FW-1:0] flags_o;
  logic          branch_taken_o;
  logic [DW-1:0] depth_o;
  logic          ovf_err_o;
  logic          udf_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [2:0] m_flags;
  logic [2:0] m_stack [$];
  logic       m_ovf;
  logic       m_udf;

  ccr_controller #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .alu_flag_i     (alu_flag_i),
    .flag_we_i      (flag_we_i),
    .setc_i         (setc_i),
    .clrc_i         (clrc_i),
    .br_check_i     (br_check_i),
    .br_cond_i      (br_cond_i),
    .int_save_i     (int_save_i),
    .rti_restore_i  (rti_restore_i),
    .flags_o        (flags_o),
    .branch_taken_o (branch_taken_o),
    .depth_o        (depth_o),
    .ovf_err_o      (ovf_err_o),
    .udf_err_o      (udf_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Jump decision straight from the rule: JMP always, else the flag whose
  // index equals the condition code (Z=0, N=1, C=2).
  function automatic logic exp_taken();
    if (!br_check_i || stall_i) return 1'b0;
    if (br_cond_i == 2'd3) return 1'b1;
    return m_flags[br_cond_i];
  endfunction

  task automatic model_step();
    logic [2:0] mg;
    logic       tk;
    if (stall_i) return;
    tk = exp_taken();
    mg = (alu_flag_i & flag_we_i) | (m_flags & ~flag_we_i);
    if (setc_i)      mg[2] = 1'b1;
    else if (clrc_i) mg[2] = 1'b0;
    if (tk && br_cond_i != 2'd3) mg[br_cond_i] = 1'b0;
    if (int_save_i) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(mg);
      else                        m_ovf = 1'b1;
      m_flags = mg;
    end else if (rti_restore_i) begin
      if (m_stack.size() > 0) m_flags = m_stack.pop_back();
      else begin
        m_flags = mg;
        m_udf   = 1'b1;
      end
    end else begin
      m_flags = mg;
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic compare();
    check("flags", 32'(flags_o), 32'(m_flags));
    check("depth", 32'(depth_o), 32'(m_stack.size()));
    check("ovf", 32'(ovf_err_o), 32'(m_ovf));
    check("udf", 32'(udf_err_o), 32'(m_udf));
    check("taken", 32'(branch_taken_o), 32'(exp_taken()));
  endtask

  // One clock: compare on the falling edge, advance model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] alu, input logic [2:0] we,
                       input logic sc, input logic cc, input logic bc, input logic [1:0] cond,
                       input logic sv, input logic rt);
    stall_i       = st;
    alu_flag_i    = alu;
    flag_we_i     = we;
    setc_i        = sc;
    clrc_i        = cc;
    br_check_i    = bc;
    br_cond_i     = cond;
    int_save_i    = sv;
    rti_restore_i = rt;
  endtask

  task automatic idle();
    drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("rst_flags", 32'(flags_o), 32'h0);
    check("rst_depth", 32'(depth_o), 32'h0);
    check("rst_ovf", 32'(ovf_err_o), 32'h0);
    check("rst_udf", 32'(udf_err_o), 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] push_vals [4];
    push_vals[0] = 3'b101;
    push_vals[1] = 3'b010;
    push_vals[2] = 3'b111;
    push_vals[3] = 3'b001;

    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Dirty the state, then reset mid-cycle.
    drive(0, 3'b111, 3'b111, 0, 0, 0, 2'b00, 1, 0);
    cycle();
    mid_reset();
    idle();
    cycle();

    // Masked write, then SETC and CLRC together.
    drive(0, 3'b111, 3'b011, 0, 0, 0, 2'b00, 0, 0);
    cycle();
    check("mask_write", 32'(flags_o), 32'h3);
    drive(0, 3'b000, 3'b000, 1, 1, 0, 2'b00, 0, 0);
    cycle();
    check("setc_wins", 32'(flags_o), 32'h7);

    // JZ taken with Z=1; same-cycle ALU write of Z=1 must lose to the clear.
    drive(0, 3'b001, 3'b001, 0, 0, 1, 2'b00, 0, 0);
    #1;
    check("jz_taken", 32'(branch_taken_o), 32'h1);
    cycle();
    check("jz_clear", 32'(flags_o), 32'h6);
    drive(0, 3'b000, 3'b000, 0, 0, 1, 2'b00, 0, 0);
    #1;
    check("jz_not_taken", 32'(branch_taken_o), 32'h0);
    cycle();
    check("jz_hold", 32'(flags_o), 32'h6);

    // Nesting to full, overflow, unwind, underflow.
    for (int i = 0; i < 4; i++) begin
      drive(0, push_vals[i], 3'b111, 0, 0, 0, 2'b00, 1, 0);
      cycle();
    end
    check("nest_depth", 32'(depth_o), 32'h4);
    drive(0, 3'b110, 3'b111, 0, 0, 0, 2'b00, 1, 0);
    cycle();
    check("ovf_set", 32'(ovf_err_o), 32'h1);
    check("ovf_depth", 32'(depth_o), 32'h4);
    for (int i = 3; i >= 0; i--) begin
      drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1);
      cycle();
      check("pop_value", 32'(flags_o), 32'(push_vals[i]));
    end
    drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1);
    cycle();
    check("udf_set", 32'(udf_err_o), 32'h1);

    // Stall holds everything while Z=1 and a JZ is presented.
    drive(1, 3'b010, 3'b111, 0, 0, 1, 2'b00, 1, 0);
    #1;
    check("stall_taken", 32'(branch_taken_o), 32'h0);
    cycle();
    check("stall_flags", 32'(flags_o), 32'h5);
    check("stall_depth", 32'(depth_o), 32'h0);

    // Save and RTI together at depth 1: save wins, no underflow.
    mid_reset();
    drive(0, 3'b110, 3'b111, 0, 0, 0, 2'b00, 1, 0);
    cycle();
    drive(0, 3'b011, 3'b111, 0, 0, 0, 2'b00, 1, 1);
    cycle();
    check("both_depth", 32'(depth_o), 32'h2);
    check("both_udf", 32'(udf_err_o), 32'h0);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1);
    cycle();
    check("both_pop1", 32'(flags_o), 32'h3);
    cycle();
    check("both_pop2", 32'(flags_o), 32'h6);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) == 0, 3'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0, 2'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0);
      if ((n % 500) == 499) mid_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ccr_controller
